// File: rtl/ppg_frame_packer.sv
// ppg_frame_packer
// Buffers ambient-corrected (led2, led1) sample pairs in a small FIFO and
// serialises each pair into a checksummed byte frame for the UART.
// Frame: HDR0 HDR1 FLAG [SEQ] L2[23:16] L2[15:8] L2[7:0] L1[23:16] L1[15:8] L1[7:0] CHK
// Optional feature macro: PACKER_SEQ_CNT_EN inserts an 8-bit rolling SEQ byte
// after FLAG. It is included in CHK and increments after every completed frame.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no frame on the wire; pops the FIFO head as soon as one exists
// ST_SEND | frame bytes presented on tx_byte, one per accepted handshake

module ppg_frame_packer #(
  parameter int         DATA_W     = 24,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HDR0       = 8'hAA,
  parameter logic [7:0] HDR1       = 8'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_led2,
  input  logic [DATA_W-1:0] s_led1,
  input  logic              data_rec,
  input  logic              ovf_clr,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              frame_done,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef PACKER_SEQ_CNT_EN
  localparam logic [3:0] LAST_IDX = 4'd10;
`else
  localparam logic [3:0] LAST_IDX = 4'd9;
`endif

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] r_mem_l2 [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_l1 [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic              r_fifo_full;
  logic              r_overflow;
  logic              w_full;
  logic              w_wr;
  logic              w_drop;
  logic [DATA_W-1:0] w_head_l2;
  logic [DATA_W-1:0] w_head_l1;

  // Frame registers
  logic [DATA_W-1:0] r_l2;
  logic [DATA_W-1:0] r_l1;
  logic              r_flag;
  logic [7:0]        r_chk;
  logic [7:0]        w_chk_new;
  logic [3:0]        r_byte_idx;
  logic [3:0]        w_idx_nxt;
  logic [7:0]        w_next_byte;
  logic [7:0]        r_tx_byte;
  logic              r_tx_valid;
  logic              r_frame_done;

  // FSM decode
  logic w_pop;
  logic w_accept;
  logic w_last;

`ifdef PACKER_SEQ_CNT_EN
  logic [7:0] r_seq;
`endif

  assign tx_byte    = r_tx_byte;
  assign tx_valid   = r_tx_valid;
  assign frame_done = r_frame_done;
  assign fifo_full  = r_fifo_full;
  assign overflow   = r_overflow;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  // A pop on the same edge frees a slot, so a full FIFO can still take a pair.
  assign w_wr      = s_valid && (!w_full || w_pop);
  assign w_drop    = s_valid && w_full && !w_pop;
  assign w_head_l2 = r_mem_l2[r_rd_ptr];
  assign w_head_l1 = r_mem_l1[r_rd_ptr];
  assign w_idx_nxt = r_byte_idx + 4'd1;

  // Next FIFO occupancy; simultaneous write and pop cancel out
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage write; contents need no reset since the count gates reads
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_l2[r_wr_ptr] <= s_led2;
      r_mem_l1[r_wr_ptr] <= s_led1;
    end
  end

  // FIFO pointers, count, registered full flag and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_fifo_full <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_nxt;
      r_fifo_full <= (w_count_nxt == CW'(FIFO_DEPTH));
      // A drop wins over a clear on the same edge so no loss goes unreported
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  // Checksum of the frame being loaded: FLAG, [SEQ] and the six data bytes
  always_comb begin
    w_chk_new = {7'b0, data_rec}
              + w_head_l2[23:16] + w_head_l2[15:8] + w_head_l2[7:0]
              + w_head_l1[23:16] + w_head_l1[15:8] + w_head_l1[7:0];
`ifdef PACKER_SEQ_CNT_EN
    w_chk_new = w_chk_new + r_seq;
`endif
  end

  // Byte that follows the one currently on tx_byte (HDR0 is loaded at pop)
  always_comb begin
    w_next_byte = r_chk;
    case (w_idx_nxt)
      4'd1: w_next_byte = HDR1;
      4'd2: w_next_byte = {7'b0, r_flag};
`ifdef PACKER_SEQ_CNT_EN
      4'd3: w_next_byte = r_seq;
      4'd4: w_next_byte = r_l2[23:16];
      4'd5: w_next_byte = r_l2[15:8];
      4'd6: w_next_byte = r_l2[7:0];
      4'd7: w_next_byte = r_l1[23:16];
      4'd8: w_next_byte = r_l1[15:8];
      4'd9: w_next_byte = r_l1[7:0];
`else
      4'd3: w_next_byte = r_l2[23:16];
      4'd4: w_next_byte = r_l2[15:8];
      4'd5: w_next_byte = r_l2[7:0];
      4'd6: w_next_byte = r_l1[23:16];
      4'd7: w_next_byte = r_l1[15:8];
      4'd8: w_next_byte = r_l1[7:0];
`endif
      default: w_next_byte = r_chk;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_tx_valid && tx_ready) begin
          w_accept = 1'b1;
          if (r_byte_idx == LAST_IDX) begin
            w_last      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame datapath: load on pop, advance on each accepted byte, hold on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_l2         <= '0;
      r_l1         <= '0;
      r_flag       <= 1'b0;
      r_chk        <= 8'd0;
      r_byte_idx   <= 4'd0;
      r_tx_byte    <= 8'd0;
      r_tx_valid   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_pop) begin
        r_l2       <= w_head_l2;
        r_l1       <= w_head_l1;
        r_flag     <= data_rec;
        r_chk      <= w_chk_new;
        r_byte_idx <= 4'd0;
        r_tx_byte  <= HDR0;
        r_tx_valid <= 1'b1;
      end else if (w_accept) begin
        if (w_last) begin
          r_tx_valid   <= 1'b0;
          r_frame_done <= 1'b1;
        end else begin
          r_byte_idx <= w_idx_nxt;
          r_tx_byte  <= w_next_byte;
        end
      end
    end
  end

`ifdef PACKER_SEQ_CNT_EN
  // Rolling frame sequence number, advanced as the CHK byte is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_seq <= 8'd0;
    else if (w_last) r_seq <= r_seq + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ppg_frame_packer.sv
// Testbench for ppg_frame_packer: table of directed frames plus hand-written
// sequences for overflow, full-FIFO pop/write, mid-frame reset and SEQ wrap
// (the last only when PACKER_SEQ_CNT_EN is defined).

module tb_ppg_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [23:0] s_led2;
  logic [23:0] s_led1;
  logic        data_rec;
  logic        ovf_clr;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        frame_done;
  logic        fifo_full;
  logic        overflow;

  always #5 clk = ~clk;

  ppg_frame_packer dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_led2     (s_led2),
    .s_led1     (s_led1),
    .data_rec   (data_rec),
    .ovf_clr    (ovf_clr),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .frame_done (frame_done),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  typedef struct {
    logic [23:0] l2;
    logic [23:0] l1;
    logic        rec;
    logic        rnd;
    logic [79:0] base;   // hand-computed 10-byte frame without SEQ
  } vec_t;

  vec_t       vecs [5];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] g_got [12];
  int         g_n;
  int         g_done;
  logic [7:0] g_seq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] l2, input logic [23:0] l1, input logic rec);
    @(negedge clk);
    s_valid  = 1'b1;
    s_led2   = l2;
    s_led1   = l1;
    data_rec = rec;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Collects one frame; tx_ready random or held high. Also checks stall stability.
  task automatic run_frame(input logic rnd, input logic chk_lat);
    logic [7:0] prev_b;
    logic       prev_stall;
    int         stall_bad;
    logic       seen;
    g_n        = 0;
    g_done     = 0;
    prev_stall = 1'b0;
    prev_b     = 8'd0;
    stall_bad  = 0;
    seen       = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 0 && chk_lat) check("latency_tx_valid", 32'(tx_valid), 32'd1);
      if (frame_done) begin
        g_done++;
        seen     = 1'b1;
        tx_ready = 1'b0;
      end else begin
        if (prev_stall && (!tx_valid || tx_byte != prev_b)) stall_bad++;
        tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tx_valid && tx_ready) begin
          if (g_n < 12) g_got[g_n] = tx_byte;
          g_n++;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_b     = tx_byte;
      end
    end
    if (!seen) check("frame_timeout", 32'd0, 32'd1);
    @(negedge clk);
    if (frame_done) g_done++;
    check("stall_stable", 32'(stall_bad), 32'd0);
    check("frame_done_count", 32'(g_done), 32'd1);
  endtask

  task automatic compare_frame(input string tag, input logic [79:0] base);
    logic [7:0] exp [11];
    int         len;
`ifdef PACKER_SEQ_CNT_EN
    len = 11;
    for (int k = 0; k < 3; k++) exp[k] = base[79-8*k -: 8];
    exp[3] = g_seq;
    for (int k = 3; k < 9; k++) exp[k+1] = base[79-8*k -: 8];
    exp[10] = base[7:0] + g_seq;
`else
    len = 10;
    for (int k = 0; k < 10; k++) exp[k] = base[79-8*k -: 8];
    exp[10] = 8'd0;
`endif
    check($sformatf("%s_len", tag), 32'(g_n), 32'(len));
    for (int k = 0; k < len && k < g_n && k < 12; k++)
      check($sformatf("%s_b%0d", tag, k), 32'(g_got[k]), 32'(exp[k]));
    g_seq = g_seq + 8'd1;
  endtask

  task automatic drain(input int exp_frames, input string tag);
    int cnt;
    cnt      = 0;
    tx_ready = 1'b1;
    for (int c = 0; c < 20 * exp_frames + 40; c++) begin
      @(negedge clk);
      if (frame_done) cnt++;
    end
    tx_ready = 1'b0;
    check(tag, 32'(cnt), 32'(exp_frames));
    g_seq = g_seq + 8'(exp_frames);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_led2   = '0;
    s_led1   = '0;
    data_rec = 1'b0;
    ovf_clr  = 1'b0;
    tx_ready = 1'b0;
    g_seq    = 8'd0;

    vecs[0] = '{24'h123456, 24'hFEDCBA, 1'b1, 1'b0, 80'hAA5501123456FEDCBA31};
    vecs[1] = '{24'h123456, 24'hFEDCBA, 1'b1, 1'b1, 80'hAA5501123456FEDCBA31};
    vecs[2] = '{24'h000000, 24'h000000, 1'b0, 1'b0, 80'hAA550000000000000000};
    vecs[3] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 80'hAA5501FFFFFFFFFFFFFB};
    vecs[4] = '{24'h800001, 24'h7FFFFE, 1'b0, 1'b0, 80'hAA55008000017FFFFEFD};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_byte",    32'(tx_byte),    32'd0);
    check("rst_tx_valid",   32'(tx_valid),   32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    check("rst_fifo_full",  32'(fifo_full),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed frames, some under random backpressure
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].l2, vecs[i].l1, vecs[i].rec);
      check($sformatf("vec%0d_lat_pre", i), 32'(tx_valid), 32'd0);
      run_frame(vecs[i].rnd, 1'b1);
      compare_frame($sformatf("vec%0d", i), vecs[i].base);
    end

    // Overflow: FIFO_DEPTH+2 pairs with the UART stalled
    tx_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 4) check("ovf_full_at_3", 32'(fifo_full), 32'd0);
      if (k == 5) begin
        check("ovf_full_at_4", 32'(fifo_full), 32'd1);
        check("ovf_none_yet",  32'(overflow),  32'd0);
      end
      s_valid  = 1'b1;
      s_led2   = 24'h100000 + 24'(k);
      s_led1   = 24'h200000 + 24'(k);
      data_rec = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("ovf_full",    32'(fifo_full), 32'd1);
    check("ovf_sticky",  32'(overflow),  32'd1);
    s_valid = 1'b1;
    ovf_clr = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_clr_vs_drop", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    drain(5, "ovf_frames");
    check("ovf_drained_full", 32'(fifo_full), 32'd0);

    // Full FIFO with a write on the same edge as an IDLE pop
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_led2  = 24'h300000 + 24'(k);
      s_led1  = 24'h400000 + 24'(k);
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("t5_full", 32'(fifo_full), 32'd1);
    tx_ready = 1'b1;
    seen     = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (frame_done) begin
        seen     = 1'b1;
        s_valid  = 1'b1;
        s_led2   = 24'h5F5F5F;
        s_led1   = 24'h6F6F6F;
        tx_ready = 1'b0;
      end
    end
    check("t5_first_frame_done", 32'(seen), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    check("t5_overflow",   32'(overflow),  32'd0);
    check("t5_still_full", 32'(fifo_full), 32'd1);
    g_seq = g_seq + 8'd1;
    drain(5, "t5_frames");

    // Reset during byte 5 of a frame, with another pair queued behind it
    tx_ready = 1'b0;
    push(24'h445566, 24'h778899, 1'b1);
    push(24'h0A0B0C, 24'h0D0E0F, 1'b1);
    tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    tx_ready = 1'b0;
`ifdef PACKER_SEQ_CNT_EN
    check("t6_byte5", 32'(tx_byte), 32'h55);
`else
    check("t6_byte5", 32'(tx_byte), 32'h66);
`endif
    rst = 1'b1;
    #1;
    check("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("t6_rst_tx_byte",  32'(tx_byte),  32'd0);
    @(negedge clk);
    rst   = 1'b0;
    g_seq = 8'd0;
    repeat (4) @(negedge clk);
    check("t6_fifo_flushed", 32'(tx_valid),  32'd0);
    check("t6_fifo_full",    32'(fifo_full), 32'd0);
    push(24'hABCDEF, 24'h010203, 1'b0);
    run_frame(1'b0, 1'b1);
    compare_frame("t6_new", 80'hAA5500ABCDEF0102036D);

`ifdef PACKER_SEQ_CNT_EN
    // SEQ wraps 8'hFF -> 8'h00: frame 257 after reset carries SEQ 00
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    g_seq = 8'd0;
    for (int f = 0; f < 257; f++) begin
      push(vecs[0].l2, vecs[0].l1, vecs[0].rec);
      run_frame(1'b0, 1'b1);
      if (f == 256) check("seq_wrap", 32'(g_got[3]), 32'h00);
      compare_frame($sformatf("seq%0d", f), vecs[0].base);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
